// File: rtl/bsg_axil_demux.sv
// bsg_axil_demux: steers one host AXI-Lite port to the m0 or m1 address window.
// Addresses outside both windows are answered locally with DECERR.
module bsg_axil_demux
  #(parameter int axil_addr_width_p = 32
  , parameter int axil_data_width_p = 32
  , parameter logic [axil_addr_width_p-1:0] m0_base_p = 32'h0000_0000
  , parameter logic [axil_addr_width_p-1:0] m0_size_p = 32'h0000_2000
  , parameter logic [axil_addr_width_p-1:0] m1_base_p = 32'h0000_2000
  , parameter logic [axil_addr_width_p-1:0] m1_size_p = 32'h0000_2000
  , parameter int axil_mosi_bus_width_lp = 2*axil_addr_width_p + axil_data_width_p + axil_data_width_p/8 + 11
  , parameter int axil_miso_bus_width_lp = axil_data_width_p + 9
  )
  (input  logic                              clk_i
  , input  logic                              reset_i
  , input  logic [axil_mosi_bus_width_lp-1:0] s_axil_bus_i
  , output logic [axil_miso_bus_width_lp-1:0] s_axil_bus_o
  , output logic [axil_mosi_bus_width_lp-1:0] m0_axil_bus_o
  , input  logic [axil_miso_bus_width_lp-1:0] m0_axil_bus_i
  , output logic [axil_mosi_bus_width_lp-1:0] m1_axil_bus_o
  , input  logic [axil_miso_bus_width_lp-1:0] m1_axil_bus_i
  );

  localparam int aw_lp = axil_addr_width_p;
  localparam int dw_lp = axil_data_width_p;

  typedef struct packed {
    logic [aw_lp-1:0]   awaddr;
    logic [2:0]         awprot;
    logic               awvalid;
    logic [dw_lp-1:0]   wdata;
    logic [dw_lp/8-1:0] wstrb;
    logic               wvalid;
    logic               bready;
    logic [aw_lp-1:0]   araddr;
    logic [2:0]         arprot;
    logic               arvalid;
    logic               rready;
  } mosi_s;

  typedef struct packed {
    logic             awready;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             arready;
    logic [dw_lp-1:0] rdata;
    logic [1:0]       rresp;
    logic             rvalid;
  } miso_s;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} r_state_e;

  // The limit is one bit wider than the address so a window ending at the top never wraps.
  function automatic logic in_window(input logic [aw_lp-1:0] addr, input logic [aw_lp-1:0] base,
                                     input logic [aw_lp-1:0] size);
    logic [aw_lp:0] limit;
    limit = {1'b0, base} + {1'b0, size};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

  mosi_s s_in, w_mosi, r_mosi, m0_out, m1_out;
  miso_s m0_in, m1_in, w_s, r_s, s_out;

  assign s_in  = s_axil_bus_i;
  assign m0_in = m0_axil_bus_i;
  assign m1_in = m1_axil_bus_i;
  assign s_axil_bus_o  = s_out;
  assign m0_axil_bus_o = m0_out;
  assign m1_axil_bus_o = m1_out;

  w_state_e         w_state;
  logic [aw_lp-1:0] aw_addr_r;
  logic [2:0]       aw_prot_r;
  logic             w_sel_r, aw_done_r, w_done_r;

  r_state_e         r_state;
  logic [aw_lp-1:0] ar_addr_r;
  logic [2:0]       ar_prot_r;
  logic             r_sel_r;

  logic aw_hit0, aw_hit1, ar_hit0, ar_hit1;
  assign aw_hit0 = in_window(s_in.awaddr, m0_base_p, m0_size_p);
  assign aw_hit1 = in_window(s_in.awaddr, m1_base_p, m1_size_p);
  assign ar_hit0 = in_window(s_in.araddr, m0_base_p, m0_size_p);
  assign ar_hit1 = in_window(s_in.araddr, m1_base_p, m1_size_p);

  logic             w_sel_awready, w_sel_wready, w_sel_bvalid;
  logic [1:0]       w_sel_bresp;
  logic             r_sel_arready, r_sel_rvalid;
  logic [1:0]       r_sel_rresp;
  logic [dw_lp-1:0] r_sel_rdata;

  assign w_sel_awready = w_sel_r ? m1_in.awready : m0_in.awready;
  assign w_sel_wready  = w_sel_r ? m1_in.wready  : m0_in.wready;
  assign w_sel_bvalid  = w_sel_r ? m1_in.bvalid  : m0_in.bvalid;
  assign w_sel_bresp   = w_sel_r ? m1_in.bresp   : m0_in.bresp;
  assign r_sel_arready = r_sel_r ? m1_in.arready : m0_in.arready;
  assign r_sel_rvalid  = r_sel_r ? m1_in.rvalid  : m0_in.rvalid;
  assign r_sel_rresp   = r_sel_r ? m1_in.rresp   : m0_in.rresp;
  assign r_sel_rdata   = r_sel_r ? m1_in.rdata   : m0_in.rdata;

  logic aw_fire, w_fire, aw_done_n, w_done_n;
  assign aw_fire   = ~aw_done_r & w_sel_awready;
  assign w_fire    = s_in.wvalid & w_sel_wready & ~w_done_r;
  assign aw_done_n = aw_done_r | aw_fire;
  assign w_done_n  = w_done_r | w_fire;

  always_comb begin
    w_mosi = '0;
    w_s    = '0;
    case (w_state)
      W_IDLE: w_s.awready = 1'b1;
      W_FWD: begin
        w_mosi.awaddr  = aw_addr_r;
        w_mosi.awprot  = aw_prot_r;
        w_mosi.awvalid = ~aw_done_r;
        w_mosi.wdata   = s_in.wdata;
        w_mosi.wstrb   = s_in.wstrb;
        w_mosi.wvalid  = s_in.wvalid & ~w_done_r;
        w_s.wready     = w_sel_wready & ~w_done_r;
      end
      W_RESP: begin
        w_s.bvalid    = w_sel_bvalid;
        w_s.bresp     = w_sel_bresp;
        w_mosi.bready = s_in.bready;
      end
      W_ERR: begin
        w_s.wready = ~w_done_r;
        w_s.bvalid = w_done_r;
        w_s.bresp  = w_done_r ? 2'b11 : 2'b00;
      end
      default: ;
    endcase
  end

  always_comb begin
    r_mosi = '0;
    r_s    = '0;
    case (r_state)
      R_IDLE: r_s.arready = 1'b1;
      R_FWD: begin
        r_mosi.araddr  = ar_addr_r;
        r_mosi.arprot  = ar_prot_r;
        r_mosi.arvalid = 1'b1;
      end
      R_RESP: begin
        r_s.rvalid    = r_sel_rvalid;
        r_s.rdata     = r_sel_rdata;
        r_s.rresp     = r_sel_rresp;
        r_mosi.rready = s_in.rready;
      end
      R_ERR: begin
        r_s.rvalid = 1'b1;
        r_s.rresp  = 2'b11;
      end
      default: ;
    endcase
  end

  // Idle and error states leave w_mosi/r_mosi at zero, so masking by select gates both masters.
  always_comb begin
    m0_out = '0;
    m1_out = '0;
    s_out  = '0;
    if (!reset_i) begin
      m0_out = (w_mosi & {axil_mosi_bus_width_lp{~w_sel_r}}) | (r_mosi & {axil_mosi_bus_width_lp{~r_sel_r}});
      m1_out = (w_mosi & {axil_mosi_bus_width_lp{w_sel_r}})  | (r_mosi & {axil_mosi_bus_width_lp{r_sel_r}});
      s_out  = w_s | r_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state   <= W_IDLE;
      aw_addr_r <= '0;
      aw_prot_r <= '0;
      w_sel_r   <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_in.awvalid) begin
          aw_addr_r <= s_in.awaddr;
          aw_prot_r <= s_in.awprot;
          w_sel_r   <= ~aw_hit0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          w_state   <= (aw_hit0 | aw_hit1) ? W_FWD : W_ERR;
        end
        W_FWD: begin
          if (aw_done_n & w_done_n) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            w_state   <= W_RESP;
          end else begin
            aw_done_r <= aw_done_n;
            w_done_r  <= w_done_n;
          end
        end
        W_RESP: if (s_in.bready & w_sel_bvalid) w_state <= W_IDLE;
        W_ERR: begin
          if (!w_done_r) begin
            if (s_in.wvalid) w_done_r <= 1'b1;
          end else if (s_in.bready) begin
            w_done_r <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= R_IDLE;
      ar_addr_r <= '0;
      ar_prot_r <= '0;
      r_sel_r   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (s_in.arvalid) begin
          ar_addr_r <= s_in.araddr;
          ar_prot_r <= s_in.arprot;
          r_sel_r   <= ~ar_hit0;
          r_state   <= (ar_hit0 | ar_hit1) ? R_FWD : R_ERR;
        end
        R_FWD:  if (r_sel_arready) r_state <= R_RESP;
        R_RESP: if (s_in.rready & r_sel_rvalid) r_state <= R_IDLE;
        R_ERR:  if (s_in.rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_axil_demux.sv
// Bench for bsg_axil_demux: random host traffic against two behavioural AXI-Lite slaves,
// checked with a flat address-map reference model.
module tb_bsg_axil_demux;

  localparam int A = 32;
  localparam int D = 32;
  localparam int MOSI_W = 2*A + D + D/8 + 11;
  localparam int MISO_W = D + 9;
  localparam longint M0_BASE = 64'h0000_0000;
  localparam longint M0_SIZE = 64'h0000_2000;
  localparam longint M1_BASE = 64'h0000_2000;
  localparam longint M1_SIZE = 64'h0000_2000;

  typedef struct packed {
    logic [A-1:0] awaddr; logic [2:0] awprot; logic awvalid;
    logic [D-1:0] wdata; logic [D/8-1:0] wstrb; logic wvalid;
    logic bready;
    logic [A-1:0] araddr; logic [2:0] arprot; logic arvalid;
    logic rready;
  } mosi_s;

  typedef struct packed {
    logic awready; logic wready; logic [1:0] bresp; logic bvalid;
    logic arready; logic [D-1:0] rdata; logic [1:0] rresp; logic rvalid;
  } miso_s;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mosi_s host_mosi;
  miso_s host_miso;
  mosi_s m_mosi [2];
  miso_s m_miso_drv [2];

  logic [MOSI_W-1:0] s_bus_i, m0_bus_o, m1_bus_o;
  logic [MISO_W-1:0] s_bus_o, m0_bus_i, m1_bus_i;

  assign s_bus_i   = host_mosi;
  assign host_miso = s_bus_o;
  assign m_mosi[0] = m0_bus_o;
  assign m_mosi[1] = m1_bus_o;
  assign m0_bus_i  = m_miso_drv[0];
  assign m1_bus_i  = m_miso_drv[1];

  bsg_axil_demux dut (
    .clk_i(clk), .reset_i(reset),
    .s_axil_bus_i(s_bus_i), .s_axil_bus_o(s_bus_o),
    .m0_axil_bus_o(m0_bus_o), .m0_axil_bus_i(m0_bus_i),
    .m1_axil_bus_o(m1_bus_o), .m1_axil_bus_i(m1_bus_i));

  int nCompared = 0;
  int nMismatched = 0;

  logic [31:0] refMem [logic [31:0]];
  logic [31:0] slaveMem [logic [31:0]];

  bit          haveAw [2], haveW [2], haveAr [2];
  logic [31:0] awAddrQ [2], wDataQ [2], arAddrQ [2];
  logic [3:0]  wStrbQ [2];
  logic [31:0] lastAw [2], lastW [2], lastAr [2];
  int          awCnt [2], wCnt [2], arCnt [2], validSeen [2];
  int          readyPct;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference decode: which window an address belongs to, -1 for none.
  function automatic int expTarget(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    if (a >= M0_BASE && a < M0_BASE + M0_SIZE) return 0;
    if (a >= M1_BASE && a < M1_BASE + M1_SIZE) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Behavioural slave: random ready, one write and one read in flight, memory backed.
  task automatic slaveModel(input int n);
    forever begin
      @(negedge clk);
      if (reset) begin
        haveAw[n] = 0; haveW[n] = 0; haveAr[n] = 0;
      end else begin
        if (m_mosi[n].awvalid || m_mosi[n].wvalid || m_mosi[n].arvalid) validSeen[n]++;
        if (m_mosi[n].awvalid && m_miso_drv[n].awready) begin
          haveAw[n] = 1; awAddrQ[n] = m_mosi[n].awaddr; lastAw[n] = m_mosi[n].awaddr; awCnt[n]++;
        end
        if (m_mosi[n].wvalid && m_miso_drv[n].wready) begin
          haveW[n] = 1; wDataQ[n] = m_mosi[n].wdata; wStrbQ[n] = m_mosi[n].wstrb; lastW[n] = m_mosi[n].wdata; wCnt[n]++;
        end
        if (m_miso_drv[n].bvalid && m_mosi[n].bready) begin
          haveAw[n] = 0; haveW[n] = 0;
        end
        if (m_mosi[n].arvalid && m_miso_drv[n].arready) begin
          haveAr[n] = 1; arAddrQ[n] = m_mosi[n].araddr; lastAr[n] = m_mosi[n].araddr; arCnt[n]++;
        end
        if (m_miso_drv[n].rvalid && m_mosi[n].rready) haveAr[n] = 0;
      end
      @(posedge clk); #1;
      if (reset) begin
        m_miso_drv[n] = '0;
      end else begin
        m_miso_drv[n].awready = !haveAw[n] && ($urandom_range(0, 99) < readyPct);
        m_miso_drv[n].wready  = !haveW[n]  && ($urandom_range(0, 99) < readyPct);
        m_miso_drv[n].arready = !haveAr[n] && ($urandom_range(0, 99) < readyPct);
        if (haveAw[n] && haveW[n] && !m_miso_drv[n].bvalid) begin
          m_miso_drv[n].bvalid = 1; m_miso_drv[n].bresp = 2'b00;
          slaveMem[awAddrQ[n]] = mergeBytes(slaveMem.exists(awAddrQ[n]) ? slaveMem[awAddrQ[n]] : 32'h0,
                                            wDataQ[n], wStrbQ[n]);
        end else if (!(haveAw[n] && haveW[n])) begin
          m_miso_drv[n].bvalid = 0;
        end
        if (haveAr[n] && !m_miso_drv[n].rvalid) begin
          m_miso_drv[n].rvalid = 1; m_miso_drv[n].rresp = 2'b00;
          m_miso_drv[n].rdata  = slaveMem.exists(arAddrQ[n]) ? slaveMem[arAddrQ[n]] : 32'h0;
        end else if (!haveAr[n]) begin
          m_miso_drv[n].rvalid = 0;
        end
      end
    end
  endtask

  task automatic hostWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int wLead, input int bDelay, input bit abandon, output logic [1:0] resp);
    int cyc;
    bit awDone, wDone, got;
    resp = 2'bxx;
    host_mosi.awaddr = addr; host_mosi.awprot = 3'($urandom);
    host_mosi.wdata = data; host_mosi.wstrb = strb; host_mosi.bready = 0;
    host_mosi.awvalid = (wLead == 0); host_mosi.wvalid = 1;
    awDone = 0; wDone = 0; cyc = 0;
    while (!(awDone && wDone) && cyc < 100) begin
      @(negedge clk);
      if (!awDone && !host_mosi.awvalid) checkOutput("wready_before_aw", host_miso.wready, 0);
      if (host_mosi.awvalid && host_miso.awready) awDone = 1;
      if (host_mosi.wvalid && host_miso.wready) wDone = 1;
      @(posedge clk); #1;
      cyc++;
      host_mosi.awvalid = !awDone && (cyc >= wLead);
      host_mosi.wvalid  = !wDone;
    end
    checkOutput("aw_w_accepted", {awDone, wDone}, 2'b11);
    for (int i = 0; i < bDelay; i++) begin
      @(negedge clk);
      checkOutput("awready_while_busy", host_miso.awready, 0);
      @(posedge clk); #1;
    end
    if (bDelay >= 4) begin
      @(negedge clk);
      checkOutput("bvalid_held", host_miso.bvalid, 1);
      @(posedge clk); #1;
    end
    if (abandon) return;
    host_mosi.bready = 1; got = 0; cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (host_miso.bvalid) begin got = 1; resp = host_miso.bresp; end
      @(posedge clk); #1;
      cyc++;
    end
    host_mosi.bready = 0;
    checkOutput("b_received", got, 1);
  endtask

  task automatic hostRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit arDone, got;
    data = 'x; resp = 'x;
    host_mosi.araddr = addr; host_mosi.arprot = 3'($urandom);
    host_mosi.arvalid = 1; host_mosi.rready = 0;
    arDone = 0; cyc = 0;
    while (!arDone && cyc < 100) begin
      @(negedge clk);
      if (host_miso.arready) arDone = 1;
      @(posedge clk); #1;
      cyc++;
    end
    host_mosi.arvalid = 0;
    checkOutput("ar_accepted", arDone, 1);
    host_mosi.rready = 1; got = 0; cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (host_miso.rvalid) begin got = 1; data = host_miso.rdata; resp = host_miso.rresp; end
      @(posedge clk); #1;
      cyc++;
    end
    host_mosi.rready = 0;
    checkOutput("r_received", got, 1);
  endtask

  task automatic checkedWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int wLead, input int bDelay);
    int tgt, vB;
    int awB [2], wB [2];
    logic [1:0] resp;
    tgt = expTarget(addr);
    for (int n = 0; n < 2; n++) begin awB[n] = awCnt[n]; wB[n] = wCnt[n]; end
    vB = validSeen[0] + validSeen[1];
    hostWrite(addr, data, strb, wLead, bDelay, 1'b0, resp);
    if (tgt < 0) begin
      checkOutput("bresp_decerr", resp, 2'b11);
      checkOutput("write_no_downstream_valid", validSeen[0] + validSeen[1] - vB, 0);
    end else begin
      checkOutput("bresp_okay", resp, 2'b00);
      checkOutput("aw_once_selected", awCnt[tgt] - awB[tgt], 1);
      checkOutput("w_once_selected", wCnt[tgt] - wB[tgt], 1);
      checkOutput("aw_none_other", awCnt[1-tgt] - awB[1-tgt], 0);
      checkOutput("awaddr_forwarded", lastAw[tgt], addr);
      checkOutput("wdata_forwarded", lastW[tgt], data);
      refMem[addr] = mergeBytes(refMem.exists(addr) ? refMem[addr] : 32'h0, data, strb);
    end
  endtask

  task automatic checkedRead(input logic [31:0] addr);
    int tgt, vB;
    int arB [2];
    logic [31:0] data;
    logic [1:0] resp;
    tgt = expTarget(addr);
    for (int n = 0; n < 2; n++) arB[n] = arCnt[n];
    vB = validSeen[0] + validSeen[1];
    hostRead(addr, data, resp);
    if (tgt < 0) begin
      checkOutput("rresp_decerr", resp, 2'b11);
      checkOutput("rdata_decerr_zero", data, 32'h0);
      checkOutput("read_no_downstream_valid", validSeen[0] + validSeen[1] - vB, 0);
    end else begin
      checkOutput("rresp_okay", resp, 2'b00);
      checkOutput("rdata", data, refMem.exists(addr) ? refMem[addr] : 32'h0);
      checkOutput("ar_once_selected", arCnt[tgt] - arB[tgt], 1);
      checkOutput("ar_none_other", arCnt[1-tgt] - arB[1-tgt], 0);
      checkOutput("araddr_forwarded", lastAr[tgt], addr);
    end
  endtask

  // One random host operation drawn from a small address pool so reads revisit written words.
  task automatic applyStimulus();
    logic [31:0] addr;
    int kind;
    kind = $urandom_range(0, 2);
    case (kind)
      0:       addr = 32'h0000_0000 + 32'(4 * $urandom_range(0, 15));
      1:       addr = 32'h0000_2000 + 32'(4 * $urandom_range(0, 15));
      default: addr = $urandom & 32'hFFFF_FFFC;
    endcase
    if ($urandom_range(0, 1) == 1)
      checkedWrite(addr, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
    else
      checkedRead(addr);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] bounds [5];
    logic [1:0] resp;
    longint rdTime, wrTime;

    host_mosi = '0;
    m_miso_drv[0] = '0;
    m_miso_drv[1] = '0;
    for (int n = 0; n < 2; n++) begin
      awCnt[n] = 0; wCnt[n] = 0; arCnt[n] = 0; validSeen[n] = 0;
      lastAw[n] = '0; lastW[n] = '0; lastAr[n] = '0;
    end
    readyPct = 100;
    reset = 1;
    fork
      slaveModel(0);
      slaveModel(1);
    join_none

    @(negedge clk);
    checkOutput("in_reset_s_outputs", host_miso, '0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checkOutput("idle_ready", {host_miso.awready, host_miso.arready}, 2'b11);
    checkOutput("idle_other_s", {host_miso.wready, host_miso.bvalid, host_miso.rvalid}, 3'b000);
    @(posedge clk); #1;

    checkedWrite(32'h0000_0010, 32'hA5A5_0001, 4'hF, 0, 0);
    slaveMem[32'h0000_2004] = 32'h1234_5678;
    refMem[32'h0000_2004]   = 32'h1234_5678;
    checkedRead(32'h0000_2004);
    checkedWrite(32'h0000_4000, 32'hDEAD_BEEF, 4'hF, 0, 0);
    checkedRead(32'h0000_FFFC);

    bounds[0] = 32'h0000_1FFC; bounds[1] = 32'h0000_2000; bounds[2] = 32'h0000_3FFC;
    bounds[3] = 32'h0000_4000; bounds[4] = 32'hFFFF_FFFC;
    for (int i = 0; i < 5; i++) begin
      checkedWrite(bounds[i], $urandom, 4'hF, 0, 0);
      checkedRead(bounds[i]);
    end

    checkedWrite(32'h0000_0020, 32'h0BAD_F00D, 4'hF, 3, 5);

    fork
      begin checkedWrite(32'h0000_0040, 32'h1357_9BDF, 4'hF, 0, 6); wrTime = $time; end
      begin checkedRead(32'h0000_2008); rdTime = $time; end
    join
    checkOutput("read_not_blocked_by_write", rdTime < wrTime, 1);

    for (int i = 0; i < 80; i++) begin
      readyPct = $urandom_range(30, 100);
      applyStimulus();
    end

    readyPct = 100;
    hostWrite(32'h0000_0100, 32'h5555_AAAA, 4'hF, 0, 2, 1'b1, resp);
    @(negedge clk);
    checkOutput("resp_pending_bvalid", host_miso.bvalid, 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_mid_s_outputs", host_miso, '0);
    checkOutput("reset_mid_m0", {m_mosi[0].awvalid, m_mosi[0].wvalid, m_mosi[0].bready,
                                 m_mosi[0].arvalid, m_mosi[0].rready}, 5'b0);
    checkOutput("reset_mid_m1", {m_mosi[1].awvalid, m_mosi[1].wvalid, m_mosi[1].bready,
                                 m_mosi[1].arvalid, m_mosi[1].rready}, 5'b0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checkOutput("post_reset_ready", {host_miso.awready, host_miso.arready}, 2'b11);
    checkOutput("post_reset_bvalid", host_miso.bvalid, 0);
    @(posedge clk); #1;
    checkedWrite(32'h0000_2010, 32'hCAFE_0123, 4'hF, 0, 0);
    checkedRead(32'h0000_2010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
